// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core datapath.
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam logic [15:0] WR_COUNT_MAX = 16'hFFFF;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] word_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One register-file read port: 32:1 select of the register array, with
// register 0 forced to zero. When REG_FILE_WR_BYPASS_EN is defined, a write
// in flight to the same address is returned in the same cycle.
module reg_file_rd_port #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W
) (
   input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
   input  logic [ADDR_W-1:0]                ra,
`ifdef REG_FILE_WR_BYPASS_EN
   input  logic                             we,
   input  logic [ADDR_W-1:0]                wa,
   input  logic [DATA_W-1:0]                wd,
`endif
   output logic [DATA_W-1:0]                rd
);

   import mips_pkg::*;

   logic addr_is_zero;

   assign addr_is_zero = (ra == ADDR_W'(REG_ZERO));

`ifdef REG_FILE_WR_BYPASS_EN
   // Select register data; a same-address write in this cycle wins.
   always_comb begin
      rd = regs[ra];
      if (addr_is_zero) begin
         rd = '0;
      end else if (we && (wa == ra)) begin
         rd = wd;
      end
   end
`else
   // Select register data; register 0 always reads zero.
   always_comb begin
      rd = regs[ra];
      if (addr_is_zero) begin
         rd = '0;
      end
   end
`endif

endmodule

// File: rtl/reg_file_wr_dec.sv
// 32 x 32 register file: one-hot decoded write port, two combinational read
// ports and a saturating count of accepted writes.
// Optional macro REG_FILE_WR_BYPASS_EN: read ports return write data of a
// same-address write in the same cycle (write-first behaviour).
module reg_file_wr_dec #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic [15:0]       wr_count
);

   import mips_pkg::*;

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] regs;
   logic [DEPTH-1:0]             wr_en;
   logic                         wr_accept;

   // A write to register 0 is dropped here, so it never counts or stores.
   assign wr_accept = we && (wa != ADDR_W'(REG_ZERO));

   // One-hot write enable decoded from the write address.
   always_comb begin
      wr_en = '0;
      if (wr_accept) begin
         wr_en[wa] = 1'b1;
      end
   end

   // Register storage; bit 0 of the decode is never set, so reg 0 stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
               regs[i] <= wd;
            end
         end
      end
   end

   // Accepted-write counter that sticks at its maximum instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_count <= '0;
      end else if (wr_accept && (wr_count != WR_COUNT_MAX)) begin
         wr_count <= wr_count + 16'd1;
      end
   end

   reg_file_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rd_port1 (
      .regs (regs),
      .ra   (ra1),
`ifdef REG_FILE_WR_BYPASS_EN
      .we   (we),
      .wa   (wa),
      .wd   (wd),
`endif
      .rd   (rd1)
   );

   reg_file_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rd_port2 (
      .regs (regs),
      .ra   (ra2),
`ifdef REG_FILE_WR_BYPASS_EN
      .we   (we),
      .wa   (wa),
      .wd   (wd),
`endif
      .rd   (rd2)
   );

endmodule

// File: tb/tb_reg_file_wr_dec.sv
// Bench for reg_file_wr_dec: behavioural register-array model checked every
// cycle, plus directed literal expectations.
module tb_reg_file_wr_dec;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  wa = '0;
   logic [31:0] wd = '0;
   logic [4:0]  ra1 = '0;
   logic [4:0]  ra2 = '0;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic [15:0] wr_count;

`ifdef REG_FILE_WR_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clk = ~clk;

   reg_file_wr_dec dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .ra1      (ra1),
      .ra2      (ra2),
      .rd1      (rd1),
      .rd2      (rd2),
      .wr_count (wr_count)
   );

   // Behavioural model: plain array of words and an integer write count.
   logic [31:0] mregs [32];
   int          mcnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) mregs[i] <= '0;
         mcnt <= 0;
      end else if (we && wa != 5'd0) begin
         mregs[wa] <= wd;
         mcnt <= (mcnt >= 65535) ? 65535 : mcnt + 1;
      end
   end

   function automatic logic [31:0] exp_rd(input logic [4:0] ra);
      if (ra == 5'd0) return 32'h0;
      if (BYP && we && wa == ra) return wd;
      return mregs[ra];
   endfunction

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Literal expectations handed from the stimulus to the checker.
   string       lit_name = "";
   logic [2:0]  lit_mask = '0;
   logic [31:0] lit_e1 = '0;
   logic [31:0] lit_e2 = '0;
   logic [15:0] lit_ec = '0;
   int          lit_seq = 0;
   int          lit_done = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Single compare process, sampling on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("model_rd1", rd1, exp_rd(ra1));
         check("model_rd2", rd2, exp_rd(ra2));
         check("model_wr_count", {16'h0, wr_count}, mcnt[31:0]);
      end
      if (lit_seq != lit_done) begin
         if (lit_mask[0]) check({lit_name, "_rd1"}, rd1, lit_e1);
         if (lit_mask[1]) check({lit_name, "_rd2"}, rd2, lit_e2);
         if (lit_mask[2]) check({lit_name, "_cnt"}, {16'h0, wr_count}, {16'h0, lit_ec});
         lit_done = lit_seq;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string nm, input logic [2:0] m, input logic [31:0] e1,
                      input logic [31:0] e2, input logic [15:0] ec);
      lit_name = nm;
      lit_mask = m;
      lit_e1   = e1;
      lit_e2   = e2;
      lit_ec   = ec;
      lit_seq++;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1;
      wa = a;
      wd = d;
      cyc();
      we = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc();
      cyc();
      rst_n = 1'b1;
      chk_en = 1'b1;
      ra1 = 5'd5;
      ra2 = 5'd31;
      lit("reset_state", 3'b111, 32'h0, 32'h0, 16'h0);
      cyc();

      // Asynchronous reset clears without waiting for a clock edge.
      wr(5'd5, 32'hDEADBEEF);
      ra1 = 5'd5;
      lit("pre_reset", 3'b101, 32'hDEADBEEF, 32'h0, 16'd1);
      cyc();
      rst_n = 1'b0;
      lit("async_reset", 3'b101, 32'h0, 32'h0, 16'd0);
      cyc();
      rst_n = 1'b1;

      // Basic write then read.
      wr(5'd8, 32'h12345678);
      ra1 = 5'd8;
      ra2 = 5'd9;
      lit("basic", 3'b111, 32'h12345678, 32'h0, 16'd1);
      cyc();

      // Writes to register 0 are ignored.
      we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0;
      lit("reg0_same", 3'b101, 32'h0, 32'h0, 16'd1);
      cyc();
      we = 1'b0;
      lit("reg0_after", 3'b101, 32'h0, 32'h0, 16'd1);
      cyc();

      // Same-cycle write/read collision.
      wr(5'd3, 32'h1);
      we = 1'b1; wa = 5'd3; wd = 32'h2; ra1 = 5'd3; ra2 = 5'd3;
      lit("collide_pre", 3'b111, BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1, 16'd2);
      cyc();
      we = 1'b0;
      lit("collide_post", 3'b111, 32'h2, 32'h2, 16'd3);
      cyc();

      // Dual-port independence.
      wr(5'd10, 32'hA);
      wr(5'd20, 32'hB);
      ra1 = 5'd20; ra2 = 5'd10;
      lit("dual", 3'b111, 32'hB, 32'hA, 16'd5);
      cyc();
      ra1 = 5'd10; ra2 = 5'd20;
      lit("dual_swap", 3'b111, 32'hA, 32'hB, 16'd5);
      cyc();

      // Reset falling on the same edge as a write.
      we = 1'b1; wa = 5'd7; wd = 32'h77777777;
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      we = 1'b0;
      cyc();
      rst_n = 1'b1;
      ra1 = 5'd7;
      lit("mid_write_reset", 3'b101, 32'h0, 32'h0, 16'd0);
      cyc();

      // Randomized traffic, read addresses often aimed at the write address.
      for (int i = 0; i < 1500; i++) begin
         we  = 1'($urandom_range(0, 1));
         wa  = 5'($urandom_range(0, 31));
         wd  = $urandom;
         ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         cyc();
      end

      // Saturation of the write counter.
      for (int i = 0; i < 65536; i++) begin
         we = 1'b1;
         wa = 5'($urandom_range(1, 31));
         wd = $urandom;
         cyc();
      end
      we = 1'b0;
      lit("saturate", 3'b100, 32'h0, 32'h0, 16'hFFFF);
      cyc();
      wr(5'd1, 32'h5);
      lit("saturate_hold", 3'b100, 32'h0, 32'h0, 16'hFFFF);
      cyc();
      cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/reg_file_wr_dec.md
Name: reg_file_wr_dec

Overview:
- Register file for the pipelined MIPS core: 32 x 32-bit, two read ports, one write port.
- The write side decodes the write address into a one-hot enable, i.e. a demultiplexer.
- Each read port is a 32:1 selection built from the shared mux primitive.
- Sits between ID (read addresses rs/rt) and WB (write address rd/rt, write data).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset. Assertion clears the array immediately; release is synchronised externally.
- we  input  1  write enable from WB stage.
- wa  input  ADDR_W  write address.
- wd  input  DATA_W  write data.
- ra1  input  ADDR_W  read address, port 1 (rs).
- ra2  input  ADDR_W  read address, port 2 (rt).
- rd1  output  DATA_W  read data, port 1.
- rd2  output  DATA_W  read data, port 2.
- wr_count  output  16  count of accepted writes (diagnostic).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All 32 registers = 0.
  - wr_count = 0.
  - rd1/rd2 therefore read 0.
  - Reset mid-operation discards any write on that edge.
- Write decode:
  - On the rising clk edge with rst_n=1 and we=1, one-hot enable bit wa is set, and reg[wa] <= wd on that edge.
  - If wa==0, no register changes; register 0 stays hardwired to 0.
- wr_count:
  - Increments by 1 on each edge with we=1 and wa!=0.
  - Saturates at 16'hFFFF; it does not wrap.
- Reads are combinational: rd1 = reg[ra1], rd2 = reg[ra2]. Latency is 0 cycles from address change.
- ra==0 always returns 0, regardless of any write to 0.
- Same-cycle write/read of the same address (we=1, wa==ra, wa!=0): see Optional Feature.
- Both read ports may address the same register; both return identical data.
- Write data takes effect for reads in the cycle after the write edge; this holds independent of the feature.
- No X propagation: unwritten registers read 0 after reset.

Optional Feature:
- Macro REG_FILE_WR_BYPASS_EN.
- Defined:
  - When we=1, wa!=0 and ra==wa, the read port returns wd combinationally in the same cycle, before the edge.
  - This emulates the write-first-half / read-second-half pipeline rule and removes one WB->ID forwarding case.
  - The bypass applies independently to each read port.
- Undefined: the read port returns the old reg[ra] until the edge. The hazard unit must forward or stall instead.

Decomposition:
- Package mips_pkg holds:
  - constants DATA_W=32 and ADDR_W=5;
  - REG_ZERO=5'd0;
  - typedefs reg_addr_t (5-bit) and word_t (32-bit).
- One natural sub-module, reg_file_rd_port: a 32:1 read select plus the optional bypass compare, instantiated twice (ports 1 and 2).
- Write decoder and storage stay in the top.

Test Plan:
- Reset: assert rst_n=0 after writing reg5=32'hDEADBEEF -> rd1 (ra1=5) = 0 immediately, without waiting for an edge; wr_count=0.
- Basic write/read: we=1, wa=8, wd=32'h12345678, one edge -> next cycle ra1=8 gives rd1=32'h12345678; ra2=9 gives rd2=0; wr_count=1.
- Register 0 protection: we=1, wa=0, wd=32'hFFFFFFFF -> ra1=0 gives rd1=0; wr_count unchanged.
- Same-cycle collision: reg3=32'h1, then we=1, wa=3, wd=32'h2, ra1=ra2=3 before the edge:
  - with REG_FILE_WR_BYPASS_EN -> rd1=rd2=32'h2;
  - without -> rd1=rd2=32'h1;
  - in both cases 32'h2 after the edge.
- Dual-port independence: write reg10=32'hA, reg20=32'hB, then ra1=20, ra2=10 -> rd1=32'hB, rd2=32'hA; swap addresses -> outputs swap in the same cycle.
- Mid-write reset and saturation:
  - rst_n falling coincident with a we=1 edge to reg7 -> reg7=0 after release.
  - Force 65536 writes -> wr_count holds 16'hFFFF.
